arp_tx_sched: RTL
=================

Name: arp_tx_sched

Overview:
- Controller that queues pending ARP replies and sequences the ARP reply encoder onto the shared MAC transmit path, one frame at a time.
- Sits between the ARP request decoder, which pushes (tha, tpa) pairs, and the ARP encoder plus MAC TX arbiter, using a req/grant handshake.
- Owns the encoder's enable, its target fields, frame length counting and inter-frame gap.

Parameters:
- DEPTH, 4: pending-reply FIFO entries; power of 2, minimum 2.
- PAYLOAD_LEN, 28: encoder output beats per reply. Use 56 for nibble/100M builds.
- GAP_CYCLES, 12: idle cycles enforced after each frame before the next tx_req.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  decoder has a reply to schedule.
- req_ready  out  1  FIFO can accept; high when not full.
- req_tha  in  48  requester MAC, captured on push.
- req_tpa  in  32  requester IP, captured on push.
- tx_req  out  1  request for the MAC TX path.
- tx_grant  in  1  arbiter grant, level-sensitive.
- enc_en  out  1  encoder enable.
- enc_tha  out  48  target HA presented to the encoder.
- enc_tpa  out  32  target PA presented to the encoder.
- tx_last  out  1  pulse on the final payload beat.
- busy  out  1  state != IDLE or FIFO non-empty.
- drop_cnt  out  8  saturating count of rejected pushes.

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, FIFO empty, req_ready=1, tx_req=0, enc_en=0, enc_tha=0, enc_tpa=0, tx_last=0, busy=0, drop_cnt=0. Reset mid-frame abandons the frame immediately; queued entries are lost.
- FIFO push: when req_valid && req_ready, the {tha,tpa} pair is written at the tail.
- req_ready is !full. It does not look ahead at a same-cycle pop, so a full FIFO refuses the push even while popping.
- req_valid && !req_ready increments drop_cnt, which saturates at 255.
- Occupancy uses a pointer pair plus one extra wrap bit; full and empty are unambiguous at wrap-around.
- States:
  - IDLE: if FIFO non-empty, latch head into enc_tha/enc_tpa, assert tx_req, go to REQ.
  - REQ: hold tx_req and enc fields. On tx_grant=1, go to SEND with byte_cnt=0. enc_en rises in the same cycle SEND is entered.
  - SEND: enc_en=1 and tx_req=1. byte_cnt increments every cycle. When byte_cnt==PAYLOAD_LEN-1: tx_last=1 for that cycle only, pop FIFO head, go to GAP. enc_en is high for exactly PAYLOAD_LEN consecutive cycles. tx_grant is ignored in SEND; once granted, the frame always completes.
  - GAP: enc_en=0, tx_req=0, gap_cnt counts 0..GAP_CYCLES-1, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Latency: from push into an empty, idle FIFO, tx_req rises 1 cycle later. With grant held high, the first enc_en cycle is 2 cycles after push.
- Field stability: enc_tha/enc_tpa are stable from REQ entry until GAP exit. Pushes during SEND never disturb them.
- Simultaneous push and pop when not full: both occur, occupancy unchanged.
- Back-to-back frames: the next tx_req is no sooner than GAP_CYCLES+1 cycles after tx_last.
- Counter widths: byte_cnt and gap_cnt are sized with $clog2 of their maximum plus 1.

Optional Feature:
- ARP_DEDUP_EN defined:
  - A push whose req_tpa equals the tpa of any valid FIFO entry is accepted (req_ready semantics unchanged) but not stored.
  - The matching entry's tha is overwritten with the new req_tha, unless it is the head entry while in REQ/SEND; in that case the push is discarded.
  - Discarded pushes do not count in drop_cnt.
- Undefined: every accepted push is stored, and duplicates produce duplicate frames.

Test Plan:
- Single reply: release reset, push tha=48'h112233445566 tpa=32'h0A000001, tx_grant tied 1. Expect tx_req rises next cycle, enc_en high exactly 28 cycles with enc_tpa=0A000001, tx_last on the 28th, tx_req low for 12 cycles, busy falls.
- Grant stall: queue one entry with tx_grant=0 for 50 cycles. Expect tx_req held, enc_en=0 throughout. Raise tx_grant, then drop it mid-SEND: frame still completes 28 beats.
- Full FIFO: with grant=0, push 6 distinct entries. Expect req_ready low after the 4th, drop_cnt=2. Then grant: 4 frames emitted in push order, each separated by 12 gap cycles.
- Push during SEND: push a new entry at beat 10 of a frame. Expect enc_tha/enc_tpa unchanged until tx_last, and the second frame carries the new fields.
- Async reset mid-frame: assert rst low at beat 15, between clock edges. Expect all outputs at reset values immediately. After release with no new pushes, no enc_en activity.
- ARP_DEDUP_EN: with grant=0, push tpa=0A000002 twice with tha A then B. Expect one frame with tha=B, drop_cnt=0.

Source files
------------

// File: rtl/arp_tx_sched.sv
// Pending ARP reply queue and frame sequencer: feeds the reply encoder onto the shared MAC TX path, one frame at a time.
// Latency: tx_req rises 1 cycle after a push into an idle, empty queue; enc_en follows 1 cycle after tx_grant.
// Backpressure: req_ready = !full (no same-cycle pop look-ahead); refused pushes bump a saturating drop_cnt. Optional ARP_DEDUP_EN merges pushes by tpa.
module arp_tx_sched #(
    parameter int DEPTH       = 4,
    parameter int PAYLOAD_LEN = 28,
    parameter int GAP_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [47:0] req_tha,
    input  logic [31:0] req_tpa,
    output logic        tx_req,
    input  logic        tx_grant,
    output logic        enc_en,
    output logic [47:0] enc_tha,
    output logic [31:0] enc_tpa,
    output logic        tx_last,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(PAYLOAD_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [47:0]   tha_mem_q [DEPTH];
    logic [47:0]   tha_mem_d [DEPTH];
    logic [31:0]   tpa_mem_q [DEPTH];
    logic [31:0]   tpa_mem_d [DEPTH];
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          tx_req_q, tx_req_d;
    logic          enc_en_q, enc_en_d;
    logic [47:0]   enc_tha_q, enc_tha_d;
    logic [31:0]   enc_tpa_q, enc_tpa_d;
    logic          tx_last_q, tx_last_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          empty, full;
    logic          push_fire, store, overwrite, pop;
    logic          dup_hit, head_busy;
    logic [AW-1:0] dup_idx;
    logic [AW-1:0] head_idx;
    logic [47:0]   head_tha;
    logic [31:0]   head_tpa;

    // The extra wrap bit separates full from empty when the index bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_idx = rd_ptr_q[AW-1:0];

`ifdef ARP_DEDUP_EN
    logic [AW:0]      occ;
    logic [DEPTH-1:0] entry_vld;

    assign occ = wr_ptr_q - rd_ptr_q;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = ({1'b0, AW'(i) - head_idx} < occ);
        end
    end

    // First live entry whose tpa matches the incoming push (tpas stay unique, so at most one).
    always_comb begin
        dup_hit = 1'b0;
        dup_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!dup_hit && entry_vld[i] && (tpa_mem_q[i] == req_tpa)) begin
                dup_hit = 1'b1;
                dup_idx = AW'(i);
            end
        end
    end

    // The head is frozen once its frame has been requested; a duplicate of it is discarded.
    assign head_busy = ((state_q == REQ) || (state_q == SEND)) && (dup_idx == head_idx);
`else
    assign dup_hit   = 1'b0;
    assign dup_idx   = '0;
    assign head_busy = 1'b0;
`endif

    assign push_fire = req_valid && !full;
    assign store     = push_fire && !dup_hit;
    assign overwrite = push_fire && dup_hit && !head_busy;
    assign pop       = (state_q == SEND) && (byte_cnt_q == BYTE_LAST);

    // A same-cycle overwrite of the head is forwarded so the IDLE latch sees the newest tha.
    assign head_tha = (overwrite && (dup_idx == head_idx)) ? req_tha : tha_mem_q[head_idx];
    assign head_tpa = tpa_mem_q[head_idx];

    // Queue storage, pointers and the saturating drop counter.
    always_comb begin
        tha_mem_d  = tha_mem_q;
        tpa_mem_d  = tpa_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (store) begin
            tha_mem_d[wr_ptr_q[AW-1:0]] = req_tha;
            tpa_mem_d[wr_ptr_q[AW-1:0]] = req_tpa;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (overwrite) begin
            tha_mem_d[dup_idx] = req_tha;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (req_valid && full && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Frame sequencer: next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_req_d   = tx_req_q;
        enc_en_d   = enc_en_q;
        enc_tha_d  = enc_tha_q;
        enc_tpa_d  = enc_tpa_q;
        tx_last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    enc_tha_d = head_tha;
                    enc_tpa_d = head_tpa;
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (tx_grant) begin
                    byte_cnt_d = '0;
                    enc_en_d   = 1'b1;
                    tx_last_d  = (PAYLOAD_LEN == 1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Grant is not re-examined: a started frame always runs to completion.
                if (byte_cnt_q == BYTE_LAST) begin
                    enc_en_d  = 1'b0;
                    tx_req_d  = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    tx_last_d  = ((byte_cnt_q + 1'b1) == BYTE_LAST);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any frame in flight and empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_req_q   <= 1'b0;
            enc_en_q   <= 1'b0;
            enc_tha_q  <= '0;
            enc_tpa_q  <= '0;
            tx_last_q  <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tha_mem_q[i] <= '0;
                tpa_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_req_q   <= tx_req_d;
            enc_en_q   <= enc_en_d;
            enc_tha_q  <= enc_tha_d;
            enc_tpa_q  <= enc_tpa_d;
            tx_last_q  <= tx_last_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                tha_mem_q[i] <= tha_mem_d[i];
                tpa_mem_q[i] <= tpa_mem_d[i];
            end
        end
    end

    assign req_ready = !full;
    assign tx_req    = tx_req_q;
    assign enc_en    = enc_en_q;
    assign enc_tha   = enc_tha_q;
    assign enc_tpa   = enc_tpa_q;
    assign tx_last   = tx_last_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (state_q != IDLE) || !empty;

endmodule
